// File: rtl/nfu3_seq_ctrl_pkg.sv
// Shared NFU-3 sequencing definitions: default sizes, FSM state codes and
// the coefficient address width helper.
package nfu3_seq_ctrl_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_NUM_SEG   = 16;
    localparam int DEF_PIPE_LAT  = 3;

    // Controller states, kept as plain constants so older tools can map them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Coefficient RAM address width; never narrower than one bit.
    function automatic int addr_width(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

endpackage

// File: rtl/nfu3_seq_ctrl_if.sv
// Bus bundle between the NFU-3 sequencer and its environment.
//
// Handshake rules: a coefficient word transfers in a cycle where
// i_cfg_valid and o_cfg_ready are both 1; a vector enters the sigmoid
// datapath in a cycle where i_in_valid and o_in_ready are both 1. The
// ready outputs depend only on controller state, never on the valid inputs,
// and a valid offered while ready is 0 is dropped with no side effect.
interface nfu3_seq_ctrl_if #(
    parameter int BIT_WIDTH = nfu3_seq_ctrl_pkg::DEF_BIT_WIDTH,
    parameter int NUM_SEG   = nfu3_seq_ctrl_pkg::DEF_NUM_SEG
);
    localparam int AW = nfu3_seq_ctrl_pkg::addr_width(NUM_SEG);

    logic                   i_load_start;
    logic                   i_cfg_valid;
    logic [2*BIT_WIDTH-1:0] i_cfg_data;
    logic                   o_cfg_ready;
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic                   o_load_coef;
    logic [2*BIT_WIDTH-1:0] o_coef;
    logic [AW-1:0]          o_coef_addr;
    logic                   o_out_valid;
    logic                   o_coef_ok;

    // Environment side: drives requests, observes controller outputs.
    modport master (
        output i_load_start, i_cfg_valid, i_cfg_data, i_in_valid,
        input  o_cfg_ready, o_in_ready, o_load_coef, o_coef, o_coef_addr,
               o_out_valid, o_coef_ok
    );

    // Controller side.
    modport slave (
        input  i_load_start, i_cfg_valid, i_cfg_data, i_in_valid,
        output o_cfg_ready, o_in_ready, o_load_coef, o_coef, o_coef_addr,
               o_out_valid, o_coef_ok
    );

endinterface

// File: rtl/nfu3_seq_ctrl_valid_pipe.sv
// Valid-bit shadow of the sigmoid datapath: one bit per pipeline stage.
module valid_pipe #(
    parameter int DEPTH = nfu3_seq_ctrl_pkg::DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] sr;

    // Shift every cycle regardless of controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(din);
        end
    end

    assign dout  = sr[DEPTH-1];
    assign empty = (sr == '0);

endmodule

// File: rtl/nfu3_seq_ctrl.sv
// NFU-3 sequencing controller: loads the sigmoid coefficient table, then
// admits NFU-2 vectors, and drains the datapath before any table reload.
module nfu3_seq_ctrl
    import nfu3_seq_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_SEG   = DEF_NUM_SEG,
    parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    nfu3_seq_ctrl_if.slave    bus,
    output logic [1:0]        fsm_state
);

    localparam int AW = addr_width(NUM_SEG);

    logic [1:0]             state;
    logic [AW-1:0]          cnt;
    logic                   coef_ok;
    logic                   cfg_ready;
    logic                   in_ready;
    logic                   cfg_accept;
    logic                   in_accept;
    logic                   last_seg;
    logic                   pipe_empty;
    logic                   pipe_out;
    logic                   load_coef;
    logic [2*BIT_WIDTH-1:0] coef;
    logic [AW-1:0]          coef_addr;

    assign cfg_ready  = (state == ST_LOAD);
    assign in_ready   = (state == ST_RUN);
    assign cfg_accept = bus.i_cfg_valid & cfg_ready;
    assign in_accept  = bus.i_in_valid & in_ready;
    assign last_seg   = (cnt == AW'(NUM_SEG - 1));

    valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .din   (in_accept),
        .dout  (pipe_out),
        .empty (pipe_empty)
    );

    // Control FSM with segment counter and table-complete flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            coef_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_load_start) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_accept) begin
                        if (last_seg) begin
                            cnt     <= '0;
                            coef_ok <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.i_load_start) begin
                        state   <= ST_DRAIN;
                        coef_ok <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Reload only once nothing is in flight in the datapath.
                    if (pipe_empty) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Coefficient RAM write port, registered one cycle after each accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_coef <= 1'b0;
            coef      <= '0;
            coef_addr <= '0;
        end else begin
            load_coef <= cfg_accept;
            if (cfg_accept) begin
                coef      <= bus.i_cfg_data;
                coef_addr <= cnt;
            end
        end
    end

    assign bus.o_cfg_ready = cfg_ready;
    assign bus.o_in_ready  = in_ready;
    assign bus.o_load_coef = load_coef;
    assign bus.o_coef      = coef;
    assign bus.o_coef_addr = coef_addr;
    assign bus.o_out_valid = pipe_out;
    assign bus.o_coef_ok   = coef_ok;
    assign fsm_state       = state;

endmodule

// File: tb/tb_nfu3_seq_ctrl.sv
// Self-checking bench for nfu3_seq_ctrl: directed load/run/drain/reset
// sequences, a cycle table for the drain corner, and random traffic
// against a timestamp-based reference model.
module tb_nfu3_seq_ctrl;
    import nfu3_seq_ctrl_pkg::*;

    localparam int BW = 16;
    localparam int NS = 16;
    localparam int PL = 3;
    localparam int AW = 4;
    localparam int DW = 2 * BW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;

    nfu3_seq_ctrl_if #(.BIT_WIDTH(BW), .NUM_SEG(NS)) bus ();

    nfu3_seq_ctrl #(.BIT_WIDTH(BW), .NUM_SEG(NS), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sb_en  = 1'b0;

    // Scoreboard of expected {addr, word} coefficient writes.
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sb_en && bus.o_load_coef === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("load_pending", 64'(exp_q.size()), 64'd1);
            end else begin
                check("load_word", 64'({bus.o_coef_addr, bus.o_coef}), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic clear_inputs();
        bus.i_load_start = 1'b0;
        bus.i_cfg_valid  = 1'b0;
        bus.i_cfg_data   = '0;
        bus.i_in_valid   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},     64'(fsm_state),       64'(ST_IDLE));
        check({tag, "_cfg_ready"}, 64'(bus.o_cfg_ready), 64'd0);
        check({tag, "_in_ready"},  64'(bus.o_in_ready),  64'd0);
        check({tag, "_load_coef"}, 64'(bus.o_load_coef), 64'd0);
        check({tag, "_coef"},      64'(bus.o_coef),      64'd0);
        check({tag, "_coef_addr"}, 64'(bus.o_coef_addr), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.o_out_valid), 64'd0);
        check({tag, "_coef_ok"},   64'(bus.o_coef_ok),   64'd0);
    endtask

    // Offer one coefficient word for one cycle; it must be written next cycle.
    task automatic send_word(input logic [DW-1:0] word, input int addr);
        check("cfg_ready_before_word", 64'(bus.o_cfg_ready), 64'd1);
        exp_q.push_back({AW'(addr), word});
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_data  = word;
        tick();
        bus.i_cfg_valid = 1'b0;
        check("load_pulse", 64'(bus.o_load_coef), 64'd1);
    endtask

    // Cycle table: inputs applied for one cycle, outputs expected afterwards.
    typedef struct {
        bit         ls;
        bit         cv;
        bit         iv;
        logic [1:0] e_st;
        bit         e_cfg;
        bit         e_in;
        bit         e_out;
        bit         e_ok;
        bit         e_load;
    } vec_t;

    function automatic vec_t mk(bit ls, bit cv, bit iv, logic [1:0] st,
                                bit e_cfg, bit e_in, bit e_out, bit e_ok, bit e_load);
        vec_t v;
        v.ls = ls; v.cv = cv; v.iv = iv; v.e_st = st;
        v.e_cfg = e_cfg; v.e_in = e_in; v.e_out = e_out; v.e_ok = e_ok; v.e_load = e_load;
        return v;
    endfunction

    vec_t tbl[13];

    // Reference model: accept timestamps drive the datapath valid and drain.
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    int            m_mode;
    int            m_cnt;
    bit            m_ok;
    bit            m_load;
    logic [DW-1:0] m_coef;
    int            m_addr;
    int            acc_q[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_ok = 0; m_load = 0; m_coef = '0; m_addr = 0;
        acc_q.delete();
    endtask

    // Stimulus and report
    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        // Full table load, back-to-back words.
        sb_en = 1'b1;
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        check("load_entry_state", 64'(fsm_state), 64'(ST_LOAD));
        check("load_in_ready", 64'(bus.o_in_ready), 64'd0);
        for (int k = 0; k < NS; k++) begin
            send_word(DW'(32'h0001_0000 + k), k);
            check("coef_ok_during_load", 64'(bus.o_coef_ok), 64'(k == NS - 1));
        end
        check("load1_done_state", 64'(fsm_state), 64'(ST_RUN));
        check("run_in_ready", 64'(bus.o_in_ready), 64'd1);
        check("run_cfg_ready", 64'(bus.o_cfg_ready), 64'd0);
        check("load1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Four accepted vectors: valid out for exactly four cycles, three later.
        for (int j = 0; j < 10; j++) begin
            bus.i_in_valid = (j < 4);
            tick();
            check("burst_out_valid", 64'(bus.o_out_valid), 64'(j >= 2 && j <= 5));
        end
        bus.i_in_valid = 1'b0;

        // Run -> drain -> load, with ignored requests along the way.
        sb_en = 1'b0;
        tbl[0]  = mk(0, 0, 1, ST_RUN,   0, 1, 0, 1, 0);
        tbl[1]  = mk(0, 1, 1, ST_RUN,   0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, ST_RUN,   0, 1, 1, 1, 0);
        tbl[3]  = mk(1, 0, 1, ST_DRAIN, 0, 0, 1, 0, 0);
        tbl[4]  = mk(1, 1, 1, ST_DRAIN, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, ST_DRAIN, 0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, ST_DRAIN, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, ST_LOAD,  1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, ST_LOAD,  1, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, ST_LOAD,  1, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, ST_LOAD,  1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, ST_LOAD,  1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, ST_LOAD,  1, 0, 0, 0, 0);
        for (int r = 0; r < 13; r++) begin
            bus.i_load_start = tbl[r].ls;
            bus.i_cfg_valid  = tbl[r].cv;
            bus.i_cfg_data   = DW'(32'h0002_0000);
            bus.i_in_valid   = tbl[r].iv;
            tick();
            check($sformatf("tbl%0d_state", r),     64'(fsm_state),       64'(tbl[r].e_st));
            check($sformatf("tbl%0d_cfg_ready", r), 64'(bus.o_cfg_ready), 64'(tbl[r].e_cfg));
            check($sformatf("tbl%0d_in_ready", r),  64'(bus.o_in_ready),  64'(tbl[r].e_in));
            check($sformatf("tbl%0d_out_valid", r), 64'(bus.o_out_valid), 64'(tbl[r].e_out));
            check($sformatf("tbl%0d_coef_ok", r),   64'(bus.o_coef_ok),   64'(tbl[r].e_ok));
            check($sformatf("tbl%0d_load_coef", r), 64'(bus.o_load_coef), 64'(tbl[r].e_load));
        end
        clear_inputs();

        // Finish that table (word 0 already written) with a 5-cycle stall after word 3.
        sb_en = 1'b1;
        for (int k = 1; k < NS; k++) begin
            send_word(DW'(32'h0002_0000 + k), k);
            if (k == 3) begin
                for (int g = 0; g < 5; g++) begin
                    tick();
                    check("gap_no_load", 64'(bus.o_load_coef), 64'd0);
                    check("gap_state", 64'(fsm_state), 64'(ST_LOAD));
                end
            end
        end
        check("load2_coef_ok", 64'(bus.o_coef_ok), 64'd1);
        check("load2_state", 64'(fsm_state), 64'(ST_RUN));
        check("load2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reload with empty datapath, reset after seven words.
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        check("reload_drain", 64'(fsm_state), 64'(ST_DRAIN));
        tick();
        check("reload_load", 64'(fsm_state), 64'(ST_LOAD));
        for (int k = 0; k < 7; k++) send_word(DW'(32'h0003_0000 + k), k);
        rst = 1'b1;
        tick();
        check_reset("midload_reset");
        rst = 1'b0;
        tick();
        check_reset("after_reset_idle");
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        send_word(DW'(32'h0004_0000), 0);
        check("fresh_load_coef_ok", 64'(bus.o_coef_ok), 64'd0);
        check("fresh_sb_empty", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        // Random traffic against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit            r_rst;
            bit            r_ls;
            bit            r_cv;
            bit            r_iv;
            logic [DW-1:0] r_data;
            bit            empty;
            bit            exp_out;
            r_rst  = ($urandom_range(0, 249) == 0);
            r_ls   = ($urandom_range(0, 24) == 0);
            r_cv   = ($urandom_range(0, 3) != 0);
            r_iv   = ($urandom_range(0, 1) == 1);
            r_data = DW'($urandom);
            rst = r_rst;
            bus.i_load_start = r_ls;
            bus.i_cfg_valid  = r_cv;
            bus.i_cfg_data   = r_data;
            bus.i_in_valid   = r_iv;

            while (acc_q.size() > 0 && acc_q[0] < cyc - PL) void'(acc_q.pop_front());
            empty = (acc_q.size() == 0);
            if (r_rst) begin
                model_reset();
            end else begin
                m_load = r_cv && (m_mode == M_LOAD);
                if (r_iv && m_mode == M_RUN) acc_q.push_back(cyc);
                if (m_load) begin
                    m_coef = r_data;
                    m_addr = m_cnt;
                end
                case (m_mode)
                    M_IDLE:  if (r_ls) begin m_mode = M_LOAD; m_cnt = 0; end
                    M_LOAD:  if (m_load) begin
                                 m_cnt = (m_cnt + 1) % NS;
                                 if (m_cnt == 0) begin m_ok = 1; m_mode = M_RUN; end
                             end
                    M_RUN:   if (r_ls) begin m_mode = M_DRAIN; m_ok = 0; end
                    default: if (empty) begin m_mode = M_LOAD; m_cnt = 0; end
                endcase
            end
            tick();
            exp_out = 1'b0;
            foreach (acc_q[i]) if (acc_q[i] + PL == cyc) exp_out = 1'b1;
            check("rnd_cfg_ready", 64'(bus.o_cfg_ready), 64'(m_mode == M_LOAD));
            check("rnd_in_ready",  64'(bus.o_in_ready),  64'(m_mode == M_RUN));
            check("rnd_out_valid", 64'(bus.o_out_valid), 64'(exp_out));
            check("rnd_coef_ok",   64'(bus.o_coef_ok),   64'(m_ok));
            check("rnd_load_coef", 64'(bus.o_load_coef), 64'(m_load));
            check("rnd_coef",      64'(bus.o_coef),      64'(m_coef));
            check("rnd_coef_addr", 64'(bus.o_coef_addr), 64'(m_addr));
        end
        rst = 1'b0;
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/nfu3_seq_ctrl.md
NFU3_SEQ_CTRL -- requirements
Module: nfu3_seq_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning the fixed-point datum width.
REQ-002 SHALL have parameter NUM_SEG, default 16, meaning the number of sigmoid segments (coefficient entries).
REQ-003 SHALL have parameter PIPE_LAT, default 3, meaning the sigmoid datapath latency in cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_load_start, input, 1 bit: request to reload the full coefficient table.
REQ-007 SHALL have port i_cfg_valid, input, 1 bit: a coefficient word is present.
REQ-008 SHALL have port i_cfg_data, input, 2*BIT_WIDTH bits: {Ai, Bi} coefficient word.
REQ-009 SHALL have port o_cfg_ready, output, 1 bit: the controller accepts a coefficient word this cycle.
REQ-010 SHALL have port i_in_valid, input, 1 bit: an NFU-2 output vector is present.
REQ-011 SHALL have port o_in_ready, output, 1 bit: the vector may enter the sigmoid datapath this cycle.
REQ-012 SHALL have port o_load_coef, output, 1 bit: coefficient RAM write enable toward NFU-3.
REQ-013 SHALL have port o_coef, output, 2*BIT_WIDTH bits: coefficient word toward NFU-3.
REQ-014 SHALL have port o_coef_addr, output, clog2(NUM_SEG) bits: coefficient RAM address.
REQ-015 SHALL have port o_out_valid, output, 1 bit: the NFU-3 output is valid this cycle.
REQ-016 SHALL have port o_coef_ok, output, 1 bit: a complete coefficient table is loaded.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN.
REQ-018 IDLE SHALL hold o_cfg_ready=0 and o_in_ready=0; i_load_start=1 SHALL move to LOAD and clear the segment counter to 0.
REQ-019 LOAD SHALL drive o_cfg_ready=1 and o_in_ready=0; an accept is defined as i_cfg_valid & o_cfg_ready.
REQ-020 On each accept, the cycle after SHALL present o_load_coef=1, o_coef=accepted word, o_coef_addr=counter value at accept; o_load_coef SHALL be 0 in every other cycle.
REQ-021 The counter SHALL increment per accept; the accept at count NUM_SEG-1 SHALL wrap the counter to 0, set o_coef_ok=1 and move to RUN.
REQ-022 A cycle in LOAD with i_cfg_valid=0 SHALL leave counter and state unchanged (stalls of any length are allowed).
REQ-023 i_load_start SHALL be ignored in LOAD and DRAIN.
REQ-024 RUN SHALL drive o_in_ready=1 and o_cfg_ready=0.
REQ-025 A PIPE_LAT-bit valid shift register SHALL shift every cycle in every state, entering (i_in_valid & o_in_ready); o_out_valid SHALL equal its last bit, so an accepted vector yields o_out_valid exactly PIPE_LAT cycles later.
REQ-026 i_load_start in RUN SHALL move to DRAIN next cycle and clear o_coef_ok; a vector offered in that same cycle SHALL be accepted.
REQ-027 DRAIN SHALL hold o_in_ready=0 and move to LOAD (counter 0) in the first cycle the valid shift register is all-zero, so in-flight data never sees a partial coefficient table.
REQ-028 i_cfg_valid outside LOAD SHALL be ignored with no side effect.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, counter 0, valid shift register 0, o_load_coef=0, o_coef=0, o_coef_addr=0, o_out_valid=0, o_coef_ok=0, o_cfg_ready=0, o_in_ready=0.
REQ-030 Reset mid-LOAD or mid-DRAIN SHALL abandon the operation; partially loaded tables SHALL NOT be reported as valid.

Structure
REQ-031 The FSM state enumeration and the default PIPE_LAT/NUM_SEG constants SHALL reside in the shared nfu package.
REQ-032 The valid shift register SHALL be a sub-module named valid_pipe (parameter DEPTH).

Verification
REQ-033 Reset, then i_load_start, then 16 back-to-back words 0x00010000+k -> o_load_coef pulses at addr 0..15 with matching data; o_coef_ok=1 after the 16th; state RUN.
REQ-034 LOAD with i_cfg_valid held 0 for 5 cycles between words 3 and 4 -> no o_load_coef during the gap; the address sequence is unbroken.
REQ-035 RUN, i_in_valid=1 for 4 cycles -> o_out_valid=1 for exactly 4 cycles, starting 3 cycles after the first accept.
REQ-036 RUN, i_in_valid and i_load_start asserted together -> that vector is accepted, o_in_ready=0 next cycle, o_out_valid 3 cycles later, LOAD entered the cycle after the pipeline empties.
REQ-037 rst after 7 accepted words -> all outputs at reset values; a fresh load then starts at addr 0.
